// File: rtl/ex_muldiv_pkg.sv
`default_nettype none
// ============================================================================
// ex_muldiv_pkg : RV32M opcodes, FSM state type, operand-sign helpers
// Rev 1.0
// ============================================================================
package ex_muldiv_pkg;

    localparam logic [2:0] MD_MUL    = 3'b000;
    localparam logic [2:0] MD_MULH   = 3'b001;
    localparam logic [2:0] MD_MULHSU = 3'b010;
    localparam logic [2:0] MD_MULHU  = 3'b011;
    localparam logic [2:0] MD_DIV    = 3'b100;
    localparam logic [2:0] MD_DIVU   = 3'b101;
    localparam logic [2:0] MD_REM    = 3'b110;
    localparam logic [2:0] MD_REMU   = 3'b111;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    function automatic logic uses_sign1(input logic [2:0] op);
        return (op == MD_MUL) || (op == MD_MULH) || (op == MD_MULHSU) ||
               (op == MD_DIV) || (op == MD_REM);
    endfunction

    function automatic logic uses_sign2(input logic [2:0] op);
        return (op == MD_MULH) || (op == MD_DIV) || (op == MD_REM);
    endfunction

endpackage
`default_nettype wire

// File: rtl/ex_muldiv_if.sv
`default_nettype none
// ============================================================================
// ex_muldiv_if : EX-stage <-> multiply/divide unit handshake bundle
// Rev 1.0
// ============================================================================
interface ex_muldiv_if #(
    parameter int XLEN = 32
);
    logic            start;
    logic [2:0]      op;
    logic [XLEN-1:0] rs1;
    logic [XLEN-1:0] rs2;
    logic            advance;
    logic            annul;
    logic            stallreq;
    logic [XLEN-1:0] result;
    logic            result_valid;

    modport master (
        output start, op, rs1, rs2, advance, annul,
        input  stallreq, result, result_valid
    );

    modport slave (
        input  start, op, rs1, rs2, advance, annul,
        output stallreq, result, result_valid
    );
endinterface
`default_nettype wire

// File: rtl/ex_muldiv_signfix.sv
`default_nettype none
// ============================================================================
// ex_muldiv_signfix : conditional negation of the magnitude result and
// selection of the architectural word. Rev 1.0
// ============================================================================
module ex_muldiv_signfix
    import ex_muldiv_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  wire logic [2:0]        op,
    input  wire logic              sign1,
    input  wire logic              sign2,
    input  wire logic [2*XLEN-1:0] acc,
    output logic      [XLEN-1:0]   result
);
    logic [2*XLEN-1:0] w_prod;
    logic [XLEN-1:0]   w_quo;
    logic [XLEN-1:0]   w_rem;

    always_comb begin
        w_prod = (sign1 ^ sign2) ? -acc : acc;
        w_quo  = (sign1 ^ sign2) ? -acc[XLEN-1:0] : acc[XLEN-1:0];
        // remainder takes the dividend's sign only
        w_rem  = sign1 ? -acc[2*XLEN-1:XLEN] : acc[2*XLEN-1:XLEN];
        result = '0;
        case (op)
            MD_MUL:                       result = w_prod[XLEN-1:0];
            MD_MULH, MD_MULHSU, MD_MULHU: result = w_prod[2*XLEN-1:XLEN];
            MD_DIV, MD_DIVU:              result = w_quo;
            MD_REM, MD_REMU:              result = w_rem;
            default:                      result = '0;
        endcase
    end
endmodule
`default_nettype wire

// File: rtl/ex_muldiv.sv
`default_nettype none
// ============================================================================
// ex_muldiv : iterative RV32M multiply/divide, 32 cycles plus divide fast paths
// Rev 1.0
// ============================================================================
module ex_muldiv
    import ex_muldiv_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  wire logic   clk,
    input  wire logic   rst,
    ex_muldiv_if.slave  bus
);
    localparam logic [XLEN-1:0] C_INT_MIN = {1'b1, {(XLEN-1){1'b0}}};

    state_t            r_state;
    logic [4:0]        r_cnt;
    logic [2*XLEN-1:0] r_acc;
    logic [XLEN-1:0]   r_opnd;
    logic              r_sign1;
    logic              r_sign2;
    logic [2:0]        r_op;

    logic              w_s1;
    logic              w_s2;
    logic [XLEN-1:0]   w_abs1;
    logic [XLEN-1:0]   w_abs2;
    logic              w_div0;
    logic              w_ovf;
    logic [XLEN:0]     w_mul_sum;
    logic [2*XLEN-1:0] w_mul_next;
    logic [XLEN:0]     w_div_part;
    logic              w_div_ge;
    logic [XLEN-1:0]   w_div_diff;
    logic [2*XLEN-1:0] w_div_next;
    logic [XLEN-1:0]   w_fixed;

    assign w_s1   = uses_sign1(bus.op) & bus.rs1[XLEN-1];
    assign w_s2   = uses_sign2(bus.op) & bus.rs2[XLEN-1];
    assign w_abs1 = w_s1 ? -bus.rs1 : bus.rs1;
    assign w_abs2 = w_s2 ? -bus.rs2 : bus.rs2;
    assign w_div0 = bus.op[2] && (bus.rs2 == '0);
    assign w_ovf  = ((bus.op == MD_DIV) || (bus.op == MD_REM)) &&
                    (bus.rs1 == C_INT_MIN) && (bus.rs2 == '1);

    // shift-add step: conditional add into the high word, then shift right
    assign w_mul_sum  = {1'b0, r_acc[2*XLEN-1:XLEN]} + {1'b0, (r_acc[0] ? r_opnd : '0)};
    assign w_mul_next = {w_mul_sum, r_acc[XLEN-1:1]};

    // restoring step: the shifted partial remainder needs XLEN+1 bits
    assign w_div_part = r_acc[2*XLEN-1:XLEN-1];
    assign w_div_ge   = (w_div_part >= {1'b0, r_opnd});
    assign w_div_diff = w_div_part[XLEN-1:0] - r_opnd;
    assign w_div_next = w_div_ge ? {w_div_diff, r_acc[XLEN-2:0], 1'b1}
                                 : {r_acc[2*XLEN-2:0], 1'b0};

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_acc   <= '0;
            r_opnd  <= '0;
            r_sign1 <= 1'b0;
            r_sign2 <= 1'b0;
            r_op    <= MD_MUL;
        end else if (bus.annul) begin
            r_state <= ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (bus.start) begin
                        r_op  <= bus.op;
                        r_cnt <= '0;
                        if (w_div0) begin
                            // quotient word all ones, remainder word is the dividend
                            r_acc   <= {bus.rs1, {XLEN{1'b1}}};
                            r_sign1 <= 1'b0;
                            r_sign2 <= 1'b0;
                            r_state <= ST_DONE;
                        end else if (w_ovf) begin
                            r_acc   <= {{XLEN{1'b0}}, C_INT_MIN};
                            r_sign1 <= 1'b0;
                            r_sign2 <= 1'b0;
                            r_state <= ST_DONE;
                        end else begin
                            r_acc   <= {{XLEN{1'b0}}, w_abs1};
                            r_opnd  <= w_abs2;
                            r_sign1 <= w_s1;
                            r_sign2 <= w_s2;
                            r_state <= ST_BUSY;
                        end
                    end
                end
                ST_BUSY: begin
                    r_acc <= r_op[2] ? w_div_next : w_mul_next;
                    r_cnt <= r_cnt + 5'd1;
                    if (r_cnt == 5'd31) begin
                        r_state <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    if (bus.advance) begin
                        r_state <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    ex_muldiv_signfix #(
        .XLEN (XLEN)
    ) u_signfix (
        .op     (r_op),
        .sign1  (r_sign1),
        .sign2  (r_sign2),
        .acc    (r_acc),
        .result (w_fixed)
    );

    assign bus.stallreq     = !bus.annul &&
                              (((r_state == ST_IDLE) && bus.start) || (r_state == ST_BUSY));
    assign bus.result_valid = !bus.annul && (r_state == ST_DONE);
    assign bus.result       = bus.result_valid ? w_fixed : '0;

endmodule
`default_nettype wire

// File: tb/tb_ex_muldiv.sv
`default_nettype none
// ============================================================================
// tb_ex_muldiv : directed self-checking bench for ex_muldiv
// Rev 1.0
// ============================================================================
module tb_ex_muldiv;
    import ex_muldiv_pkg::*;

    logic clk;
    logic rst;
    int   n_tests;
    int   n_fail;

    ex_muldiv_if #(.XLEN(32)) bus ();

    ex_muldiv #(.XLEN(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Drives an op from the current cycle, counts stall cycles, checks the DONE cycle.
    task automatic run(input string tag, input logic [2:0] o, input logic [31:0] a,
                       input logic [31:0] b, input logic adv, input int exp_n,
                       input logic [31:0] exp_r);
        int n;
        bus.start   = 1'b1;
        bus.op      = o;
        bus.rs1     = a;
        bus.rs2     = b;
        bus.advance = adv;
        n = 0;
        #1;
        while (bus.stallreq && n < 40) begin
            n++;
            tick();
            #1;
        end
        chk({tag, "_stall"}, 32'(n), 32'(exp_n));
        chk({tag, "_valid"}, {31'd0, bus.result_valid}, 32'd1);
        chk({tag, "_result"}, bus.result, exp_r);
    endtask

    task automatic retire();
        bus.start   = 1'b0;
        bus.advance = 1'b1;
        tick();
    endtask

    initial begin
        bool_seen_init: begin end
        n_tests = 0;
        n_fail  = 0;
        rst = 1'b1;
        bus.start = 1'b0; bus.op = MD_MUL; bus.rs1 = '0; bus.rs2 = '0;
        bus.advance = 1'b1; bus.annul = 1'b0;
        tick(); tick();
        #1;
        chk("rst_stallreq", {31'd0, bus.stallreq}, 32'd0);
        chk("rst_valid", {31'd0, bus.result_valid}, 32'd0);
        chk("rst_result", bus.result, 32'd0);
        rst = 1'b0;
        tick();

        run("mul", MD_MUL, 32'd7, 32'd6, 1'b1, 33, 32'd42); retire();
        run("mulh", MD_MULH, 32'h8000_0000, 32'h8000_0000, 1'b1, 33, 32'h4000_0000); retire();
        run("mulhsu", MD_MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 33, 32'hFFFF_FFFF); retire();
        run("mulhu", MD_MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 33, 32'hFFFF_FFFE); retire();
        run("mul_neg", MD_MUL, 32'hFFFF_FFFD, 32'd5, 1'b1, 33, 32'hFFFF_FFF1); retire();
        run("div", MD_DIV, 32'hFFFF_FFF9, 32'd2, 1'b1, 33, 32'hFFFF_FFFD); retire();
        run("rem", MD_REM, 32'hFFFF_FFF9, 32'd2, 1'b1, 33, 32'hFFFF_FFFF); retire();
        run("divu", MD_DIVU, 32'd100, 32'd7, 1'b1, 33, 32'd14); retire();
        run("remu", MD_REMU, 32'd100, 32'd7, 1'b1, 33, 32'd2); retire();
        run("divu_big", MD_DIVU, 32'hFFFF_FFFF, 32'h8000_0001, 1'b1, 33, 32'd1); retire();
        run("remu_big", MD_REMU, 32'hFFFF_FFFF, 32'h8000_0001, 1'b1, 33, 32'h7FFF_FFFE); retire();
        run("div0", MD_DIV, 32'd5, 32'd0, 1'b1, 1, 32'hFFFF_FFFF); retire();
        run("rem0", MD_REM, 32'd5, 32'd0, 1'b1, 1, 32'd5); retire();
        run("divovf", MD_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 1, 32'h8000_0000); retire();
        run("removf", MD_REM, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 1, 32'd0); retire();

        // annul in BUSY cycle 10
        bus.start = 1'b1; bus.op = MD_MUL; bus.rs1 = 32'd3; bus.rs2 = 32'd5;
        for (int i = 0; i < 10; i++) tick();
        bus.annul = 1'b1;
        #1;
        chk("annul_stallreq", {31'd0, bus.stallreq}, 32'd0);
        chk("annul_valid", {31'd0, bus.result_valid}, 32'd0);
        tick();
        bus.annul = 1'b0;
        bus.start = 1'b0;
        #1;
        chk("post_annul_stallreq", {31'd0, bus.stallreq}, 32'd0);
        begin
            logic seen;
            seen = 1'b0;
            for (int i = 0; i < 40; i++) begin
                if (bus.result_valid) seen = 1'b1;
                tick();
            end
            chk("post_annul_no_valid", {31'd0, seen}, 32'd0);
        end

        // annul and start together in IDLE
        bus.start = 1'b1; bus.annul = 1'b1; bus.op = MD_DIVU; bus.rs1 = 32'd9; bus.rs2 = 32'd3;
        #1;
        chk("idle_annul_stallreq", {31'd0, bus.stallreq}, 32'd0);
        tick();
        bus.start = 1'b0; bus.annul = 1'b0;
        #1;
        chk("idle_annul_not_taken", {31'd0, bus.stallreq}, 32'd0);
        tick();

        // rst mid-BUSY
        bus.start = 1'b1; bus.op = MD_DIVU; bus.rs1 = 32'd100; bus.rs2 = 32'd7;
        for (int i = 0; i < 5; i++) tick();
        rst = 1'b1;
        bus.start = 1'b0;
        tick();
        #1;
        chk("midrst_stallreq", {31'd0, bus.stallreq}, 32'd0);
        chk("midrst_valid", {31'd0, bus.result_valid}, 32'd0);
        chk("midrst_result", bus.result, 32'd0);
        rst = 1'b0;
        tick();

        // hold in DONE with start still asserted, then back-to-back new op
        run("hold", MD_DIVU, 32'd100, 32'd7, 1'b0, 33, 32'd14);
        for (int k = 0; k < 3; k++) begin
            tick();
            #1;
            chk($sformatf("hold%0d_result", k), bus.result, 32'd14);
            chk($sformatf("hold%0d_valid", k), {31'd0, bus.result_valid}, 32'd1);
            chk($sformatf("hold%0d_stallreq", k), {31'd0, bus.stallreq}, 32'd0);
        end
        bus.advance = 1'b1; bus.op = MD_DIVU; bus.rs1 = 32'd9; bus.rs2 = 32'd3;
        tick();
        run("b2b_divu", MD_DIVU, 32'd9, 32'd3, 1'b1, 33, 32'd3);
        retire();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
`default_nettype wire
